// File: rtl/dram_responder.sv
// dram_responder: memory-side model below the LLC. Accepts read-block and
// write-word requests into an in-order FIFO. Writes commit to a word-addressed
// backing store. Reads return a block as a burst of word beats after a fixed
// latency.
module dram_responder #(
    parameter int unsigned W         = 64,
    parameter int unsigned B         = 64,
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned QDEPTH    = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         hc_valid_in,
    output logic         hc_ready_out,
    input  logic [W-1:0] hc_addr_in,
    input  logic [W-1:0] hc_value_in,
    input  logic         hc_we_in,
    output logic         hc_valid_out,
    input  logic         hc_ready_in,
    output logic [W-1:0] hc_addr_out,
    output logic [W-1:0] hc_value_out
);

    localparam int unsigned WORD_BYTES = W / 8;
    localparam int unsigned OFF_W      = $clog2(WORD_BYTES);
    localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
    localparam int unsigned BEATS      = (B * 8) / W;
    localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W      = $clog2(QDEPTH) + 1;
    localparam int unsigned LAT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef struct packed {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] value;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    // Request FIFO
    req_t             fifo_mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d_c;
    logic             ready_q;
    logic             push_c;
    logic             pop_c;
    req_t             head_c;

    // Backing store (not reset; contents undefined until written)
    logic [W-1:0]     mem [MEM_WORDS];
    logic             mem_we_c;

    // Burst engine
    state_t           fsm;
    state_t           fsm_d;
    logic [LAT_W-1:0] lat_q;
    logic [LAT_W-1:0] lat_d;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_d;
    logic [BEAT_W-1:0] beat_nxt_c;
    logic [W-1:0]     base_q;
    logic [W-1:0]     base_d;
    logic             valid_q;
    logic             valid_d;
    logic [W-1:0]     addr_q;
    logic [W-1:0]     addr_d;
    logic [W-1:0]     value_q;
    logic [W-1:0]     value_d;

    assign push_c     = hc_valid_in && ready_q;
    assign head_c     = fifo_mem[rd_ptr_q];
    assign beat_nxt_c = beat_q + BEAT_W'(1);

    // Occupancy after this edge's push and pop
    always_comb begin
        count_d_c = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // FIFO pointers, occupancy and registered ready (no bypass when full)
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d_c;
            ready_q <= (count_d_c != CNT_W'(QDEPTH));
        end
    end

    // FIFO payload storage
    always_ff @(posedge clk_in) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= '{we: hc_we_in, addr: hc_addr_in, value: hc_value_in};
        end
    end

    // Write commit into the backing store; low byte-offset bits are ignored
    always_ff @(posedge clk_in) begin
        if (mem_we_c) begin
            mem[head_c.addr[OFF_W +: IDX_W]] <= head_c.value;
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_d;
        end
    end

    // Next state, dequeue decision and next beat registers.
    // BURST spends its first cycle loading beat 0 so the first valid lands
    // exactly LATENCY edges after the dequeue edge for every LATENCY >= 1.
    always_comb begin
        fsm_d    = fsm;
        pop_c    = 1'b0;
        mem_we_c = 1'b0;
        lat_d    = lat_q;
        beat_d   = beat_q;
        base_d   = base_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        value_d  = value_q;

        case (fsm)
            IDLE: begin
                if (count_q != '0) begin
                    pop_c = 1'b1;
                    if (head_c.we) begin
                        mem_we_c = 1'b1;
                    end else begin
                        base_d = head_c.addr & ~W'(B - 1);
                        lat_d  = LAT_W'(LATENCY - 1);
                        beat_d = '0;
                        fsm_d  = (LATENCY == 1) ? BURST : WAIT;
                    end
                end
            end

            WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    fsm_d = BURST;
                end
            end

            BURST: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    addr_d  = base_q;
                    value_d = mem[base_q[OFF_W +: IDX_W]];
                end else if (hc_ready_in) begin
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        valid_d = 1'b0;
                        fsm_d   = IDLE;
                    end else begin
                        beat_d  = beat_nxt_c;
                        addr_d  = base_q + (W'(beat_nxt_c) << OFF_W);
                        value_d = mem[base_q[OFF_W +: IDX_W] + IDX_W'(beat_nxt_c)];
                    end
                end
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // Burst counters and registered response outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            lat_q   <= '0;
            beat_q  <= '0;
            base_q  <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            value_q <= '0;
        end else begin
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            value_q <= value_d;
        end
    end

    assign hc_ready_out = ready_q;
    assign hc_valid_out = valid_q;
    assign hc_addr_out  = addr_q;
    assign hc_value_out = value_q;

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: request table with expected bursts, a beat
// scoreboard, and directed sequences for latency, stalls, full FIFO and reset.
module tb_dram_responder;

    typedef struct packed {
        logic             we;
        logic [63:0]      addr;
        logic [63:0]      data;
        logic [63:0]      base;
        logic [7:0][63:0] vals;
    } vec_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] value;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        hc_valid_in, hc_ready_out, hc_we_in, hc_valid_out, hc_ready_in;
    logic [63:0] hc_addr_in, hc_value_in, hc_addr_out, hc_value_out;

    logic        d1_valid_in, d1_ready_out, d1_we_in, d1_valid_out, d1_ready_in;
    logic [63:0] d1_addr_in, d1_value_in, d1_addr_out, d1_value_out;

    int          checks   = 0;
    int          failures = 0;
    int          mon_beat = 0;
    beat_t       exp_q[$];
    vec_t        vecs[$];

    always #5 clk = ~clk;

    dram_responder #(.LATENCY(4)) dut0 (
        .clk_in(clk), .rst_in(rst),
        .hc_valid_in(hc_valid_in), .hc_ready_out(hc_ready_out),
        .hc_addr_in(hc_addr_in), .hc_value_in(hc_value_in), .hc_we_in(hc_we_in),
        .hc_valid_out(hc_valid_out), .hc_ready_in(hc_ready_in),
        .hc_addr_out(hc_addr_out), .hc_value_out(hc_value_out)
    );

    dram_responder #(.LATENCY(1)) dut1 (
        .clk_in(clk), .rst_in(rst),
        .hc_valid_in(d1_valid_in), .hc_ready_out(d1_ready_out),
        .hc_addr_in(d1_addr_in), .hc_value_in(d1_value_in), .hc_we_in(d1_we_in),
        .hc_valid_out(d1_valid_out), .hc_ready_in(d1_ready_in),
        .hc_addr_out(d1_addr_out), .hc_value_out(d1_value_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic vec_t mkw(input logic [63:0] a, input logic [63:0] d);
        vec_t v;
        v      = '0;
        v.we   = 1'b1;
        v.addr = a;
        v.data = d;
        return v;
    endfunction

    function automatic vec_t mkr(input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] v0, input logic [63:0] vb);
        vec_t v;
        v      = '0;
        v.addr = a;
        v.base = b;
        for (int k = 0; k < 8; k++) v.vals[k] = vb + 64'(k);
        v.vals[0] = v0;
        return v;
    endfunction

    // Expected beats of a block whose word k holds vb+k
    task automatic push_block(input logic [63:0] base, input logic [63:0] vb);
        beat_t e;
        for (int k = 0; k < 8; k++) begin
            e.addr  = base + 64'(8 * k);
            e.value = vb + 64'(k);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every valid cycle is compared against the oldest expected beat
    task automatic monitor_loop();
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_beat = 0;
            end else begin
                if (mon_beat != 0) check("valid_held_mid_burst", 64'(hc_valid_out), 64'd1);
                if (hc_valid_out) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        e = exp_q[0];
                        check("beat_addr", hc_addr_out, e.addr);
                        check("beat_value", hc_value_out, e.value);
                        if (hc_ready_in) begin
                            void'(exp_q.pop_front());
                            mon_beat = (mon_beat + 1) % 8;
                        end
                    end
                end
            end
        end
    endtask

    // Hold a request on dut0 until accepted; call at posedge+1, returns at posedge+1
    task automatic send(input logic we, input logic [63:0] a, input logic [63:0] d);
        int   n;
        logic ok;
        n           = 0;
        hc_valid_in = 1'b1;
        hc_we_in    = we;
        hc_addr_in  = a;
        hc_value_in = d;
        forever begin
            @(negedge clk);
            ok = hc_ready_out;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 300) begin
                fail_now("send_timeout");
                break;
            end
        end
        hc_valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || hc_valid_out) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int          n;
        int          nb;
        logic        found;
        logic [63:0] a;

        rst         = 1'b1;
        hc_valid_in = 1'b0; hc_we_in = 1'b0; hc_addr_in = '0; hc_value_in = '0;
        hc_ready_in = 1'b1;
        d1_valid_in = 1'b0; d1_we_in = 1'b0; d1_addr_in = '0; d1_value_in = '0;
        d1_ready_in = 1'b1;

        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(hc_ready_out), 64'd1);
        check("rst_valid", 64'(hc_valid_out), 64'd0);
        check("rst_addr", hc_addr_out, 64'd0);
        check("rst_value", hc_value_out, 64'd0);
        check("rst_d1_ready", 64'(d1_ready_out), 64'd1);
        rst = 1'b0;

        // Request table: writes, aliased writes, offset reads, read/write ordering
        for (int k = 0; k < 8; k++) vecs.push_back(mkw(64'h1000 + 64'(8 * k), 64'hA0 + 64'(k)));
        vecs.push_back(mkr(64'h1010, 64'h1000, 64'hA0, 64'hA0));
        for (int k = 0; k < 8; k++) vecs.push_back(mkw(64'h3040 + 64'(8 * k), 64'hB0 + 64'(k)));
        vecs.push_back(mkr(64'h107F, 64'h1040, 64'hB0, 64'hB0));
        for (int k = 0; k < 8; k++) vecs.push_back(mkw(64'h2000 + 64'(9 * k), 64'hC0 + 64'(k)));
        vecs.push_back(mkr(64'h2000, 64'h2000, 64'hC0, 64'hC0));
        vecs.push_back(mkw(64'h2005, 64'hDEAD));
        vecs.push_back(mkr(64'h2038, 64'h2000, 64'hDEAD, 64'hC0));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (!vecs[i].we) begin
                for (int k = 0; k < 8; k++) begin
                    exp_q.push_back('{addr: vecs[i].base + 64'(8 * k), value: vecs[i].vals[k]});
                end
            end
            send(vecs[i].we, vecs[i].addr, vecs[i].data);
        end
        drain("table");

        // First beat LATENCY edges after dequeue (dequeue is one edge after enqueue)
        push_block(64'h1000, 64'hA0);
        send(1'b0, 64'h1000, 64'd0);
        n = 0;
        while (!hc_valid_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("read_latency_edges", 64'(n), 64'd5);
        drain("latency");

        // Backpressure on beat 2 for five cycles
        push_block(64'h1040, 64'hB0);
        send(1'b0, 64'h1040, 64'd0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (hc_valid_out && hc_addr_out == 64'h1050) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("bp_reached_beat2", 64'(found), 64'd1);
        hc_ready_in = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        hc_ready_in = 1'b1;
        drain("backpressure");

        // Full FIFO: one burst stalled, four reads fill the queue, fifth waits
        hc_ready_in = 1'b0;
        push_block(64'h1000, 64'hA0);
        send(1'b0, 64'h1000, 64'd0);
        n = 0;
        while (!hc_valid_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("full_first_valid", 64'(hc_valid_out), 64'd1);
        for (int i = 0; i < 4; i++) begin
            a = (i % 2 == 0) ? 64'h1040 : 64'h1000;
            push_block(a, (i % 2 == 0) ? 64'hB0 : 64'hA0);
            send(1'b0, a, 64'd0);
            check("full_ready_after_enq", 64'(hc_ready_out), (i < 3) ? 64'd1 : 64'd0);
        end
        push_block(64'h1040, 64'hB0);
        hc_valid_in = 1'b1; hc_we_in = 1'b0; hc_addr_in = 64'h1040; hc_value_in = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("full_ready_held_low", 64'(hc_ready_out), 64'd0);
        end
        hc_ready_in = 1'b1;
        send(1'b0, 64'h1040, 64'd0);
        drain("fifo_full");

        // Reset during beat 3 of a burst
        push_block(64'h1000, 64'hA0);
        send(1'b0, 64'h1000, 64'd0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (hc_valid_out && hc_addr_out == 64'h1018) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("rst_reached_beat3", 64'(found), 64'd1);
        check("rst_beats_before", 64'(exp_q.size()), 64'd5);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 64'(hc_valid_out), 64'd0);
        check("rst_mid_ready", 64'(hc_ready_out), 64'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nb  = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (hc_valid_out) nb++;
        end
        check("post_reset_beats", 64'(nb), 64'd0);

        // LATENCY=1 instance: aliased read of word 0
        d1_valid_in = 1'b1; d1_we_in = 1'b1; d1_addr_in = 64'h0; d1_value_in = 64'h55;
        @(posedge clk);
        #1;
        d1_valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        d1_valid_in = 1'b1; d1_we_in = 1'b0; d1_addr_in = 64'h2000; d1_value_in = '0;
        @(posedge clk);
        #1;
        d1_valid_in = 1'b0;
        n = 0;
        while (!d1_valid_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("lat1_edges", 64'(n), 64'd2);
        check("lat1_beat0_addr", d1_addr_out, 64'h2000);
        check("lat1_beat0_value", d1_value_out, 64'h55);
        nb = 0;
        n  = 0;
        while (d1_valid_out && n < 50) begin
            nb++;
            @(posedge clk);
            #1;
            n++;
        end
        check("lat1_beat_count", 64'(nb), 64'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
